sr_ff_ctrl: RTL and testbench

// Controller for the other end of the sr_ff interface. It accepts a requested

---
 rtl/sr_ff_ctrl_if.sv | 25 ++
 rtl/sr_ff_ctrl.sv | 116 +++++++++++
 tb/tb_sr_ff_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sr_ff_ctrl_if.sv
// Handshake and flop-feedback bundle between a requester/sr_ff pair and sr_ff_ctrl.
// The slave modport is the controller's view; the master modport is the requester and flop side.
interface sr_ff_ctrl_if;
    logic       req_valid;
    logic       req_level;
    logic       req_ready;
    logic       s;
    logic       r;
    logic       q;
    logic       nq;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output req_valid, req_level, q, nq,
        input  req_ready, s, r, busy, done, err, err_code
    );

    modport slave (
        input  req_valid, req_level, q, nq,
        output req_ready, s, r, busy, done, err, err_code
    );
endinterface

// File: rtl/sr_ff_ctrl.sv
// Drives one-sided S/R pulses into an SR flop on request, then watches q/nq until
// the flop settles. It reports done, or err with a code for a timeout or illegal feedback.
module sr_ff_ctrl #(
    parameter int PULSE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CW             = 4
) (
    input logic         clk,
    input logic         rst,
    sr_ff_ctrl_if.slave bus
);
    // A zero pulse length still needs one driven cycle; the timeout needs at least one sample.
    localparam int PULSE_EFF = (PULSE_CYCLES < 1) ? 1 : PULSE_CYCLES;
    localparam int TO_EFF    = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_EFF - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TO_EFF - 1);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, DONE, ERR} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          lvl_q;
    logic          s_q;
    logic          r_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [1:0]    code_q;

    // The counter stops at its terminal value, so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        lvl_q   <= bus.req_level;
                        code_q  <= 2'b00;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (bus.q == bus.req_level && bus.nq == !bus.req_level) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRIVE;
                            s_q     <= bus.req_level;
                            r_q     <= !bus.req_level;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_q >= PULSE_LAST) begin
                        state_q <= SETTLE;
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SETTLE: begin
                    if (bus.q == bus.nq) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        code_q  <= 2'b10;
                    end else if (bus.q == lvl_q && bus.nq == !lvl_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (cnt_q >= TO_LAST) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        code_q  <= 2'b01;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE, ERR: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
endmodule

// File: tb/tb_sr_ff_ctrl.sv
// Directed and random-stream checks of sr_ff_ctrl against a behavioural SR flop
// whose feedback can be held stuck or forced illegal.
module tb_sr_ff_ctrl;
    logic clk;
    logic rst;
    sr_ff_ctrl_if bus();

    int checks = 0;
    int passes = 0;

    // Flop model: 0 = ideal, 1 = stuck at q=0/nq=1, 2 = forced q=nq=1.
    int   mode = 0;
    logic flopQ;
    logic presetEn = 1'b0;
    logic presetVal = 1'b0;

    always @(presetEn, presetVal, bus.s, bus.r) begin
        if (presetEn)   flopQ = presetVal;
        else if (bus.s) flopQ = 1'b1;
        else if (bus.r) flopQ = 1'b0;
    end

    assign bus.q  = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : flopQ;
    assign bus.nq = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b1 : !flopQ;

    sr_ff_ctrl #(.PULSE_CYCLES(2), .TIMEOUT_CYCLES(8), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic level);
        bus.req_valid = valid;
        bus.req_level = level;
    endtask

    task automatic presetFlop(input logic val);
        presetVal = val;
        presetEn  = 1'b1;
        #1;
        presetEn  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    int predicted;
    int completions;
    int errs;
    int overlaps;
    int waited;
    logic v;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        presetFlop(1'b0);
        #23;
        rst = 1'b0;
        tick();

        // Reset state.
        checkOutput("rst_s", {7'd0, bus.s}, 8'd0);
        checkOutput("rst_r", {7'd0, bus.r}, 8'd0);
        checkOutput("rst_ready", {7'd0, bus.req_ready}, 8'd1);
        checkOutput("rst_busy", {7'd0, bus.busy}, 8'd0);
        checkOutput("rst_code", {6'd0, bus.err_code}, 8'd0);

        // Set from q=0 with an ideal flop.
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("set_s_e0", {7'd0, bus.s}, 8'd1);
        checkOutput("set_r_e0", {7'd0, bus.r}, 8'd0);
        checkOutput("set_busy", {7'd0, bus.busy}, 8'd1);
        checkOutput("set_ready", {7'd0, bus.req_ready}, 8'd0);
        tick();
        checkOutput("set_s_e1", {7'd0, bus.s}, 8'd1);
        checkOutput("set_r_e1", {7'd0, bus.r}, 8'd0);
        tick();
        checkOutput("set_s_e2", {7'd0, bus.s}, 8'd0);
        checkOutput("set_done_e2", {7'd0, bus.done}, 8'd0);
        tick();
        checkOutput("set_done_e3", {7'd0, bus.done}, 8'd1);
        checkOutput("set_q", {7'd0, bus.q}, 8'd1);
        tick();
        checkOutput("set_done_e4", {7'd0, bus.done}, 8'd0);
        checkOutput("set_ready_e4", {7'd0, bus.req_ready}, 8'd1);

        // Already at the requested level: immediate done, no pulse.
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("nop_done", {7'd0, bus.done}, 8'd1);
        checkOutput("nop_s", {7'd0, bus.s}, 8'd0);
        checkOutput("nop_busy", {7'd0, bus.busy}, 8'd1);
        tick();
        checkOutput("nop_ready", {7'd0, bus.req_ready}, 8'd1);

        // Reset from q=1 with an ideal flop: r pulse.
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("clr_r", {7'd0, bus.r}, 8'd1);
        checkOutput("clr_s", {7'd0, bus.s}, 8'd0);
        tick(); tick(); tick();
        checkOutput("clr_done", {7'd0, bus.done}, 8'd1);
        checkOutput("clr_q", {7'd0, bus.q}, 8'd0);
        tick();

        // Stuck flop: timeout after 2 drive and 8 settle cycles.
        mode = 1;
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("to_code_clr", {6'd0, bus.err_code}, 8'd0);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("to_err_early", {7'd0, bus.err}, 8'd0);
        tick();
        checkOutput("to_err", {7'd0, bus.err}, 8'd1);
        checkOutput("to_code", {6'd0, bus.err_code}, 8'd1);
        tick();
        checkOutput("to_err_drop", {7'd0, bus.err}, 8'd0);
        checkOutput("to_idle", {7'd0, bus.req_ready}, 8'd1);
        checkOutput("to_code_hold", {6'd0, bus.err_code}, 8'd1);

        // Illegal feedback during SETTLE.
        mode = 0;
        presetFlop(1'b1);
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("ill_code_clr", {6'd0, bus.err_code}, 8'd0);
        tick(); tick();
        mode = 2;
        tick();
        checkOutput("ill_err", {7'd0, bus.err}, 8'd1);
        checkOutput("ill_code", {6'd0, bus.err_code}, 8'd2);
        tick();
        checkOutput("ill_ready", {7'd0, bus.req_ready}, 8'd1);
        mode = 0;

        // Asynchronous reset mid-pulse.
        presetFlop(1'b0);
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("ar_s_before", {7'd0, bus.s}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_s", {7'd0, bus.s}, 8'd0);
        checkOutput("ar_busy", {7'd0, bus.busy}, 8'd0);
        checkOutput("ar_ready", {7'd0, bus.req_ready}, 8'd1);
        #3;
        rst = 1'b0;
        tick();

        // Random request stream against the ideal flop.
        predicted = 0; completions = 0; errs = 0; overlaps = 0;
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(0, 1));
            applyStimulus(v, 1'($urandom_range(0, 1)));
            if (bus.req_ready && v) predicted++;
            tick();
            if (bus.s && bus.r) overlaps++;
            if (bus.done || bus.err) completions++;
            if (bus.err) errs++;
        end
        applyStimulus(1'b0, 1'b0);
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            tick();
            if (bus.s && bus.r) overlaps++;
            if (bus.done || bus.err) completions++;
            if (bus.err) errs++;
            waited++;
        end
        checkOutput("rnd_drain", {7'd0, bus.req_ready}, 8'd1);
        checkOutput("rnd_overlap", 8'(overlaps), 8'd0);
        checkOutput("rnd_errs", 8'(errs), 8'd0);
        checkOutput("rnd_completions", 8'(completions), 8'(predicted));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
